// File: rtl/fxp_pkg.sv
// Shared types and helpers for the sequential sign-magnitude fixed-point divider.
package fxp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // All ones in the low n-1 bits: the largest representable magnitude.
    function automatic logic [63:0] fxp_max_mag(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // One restoring step per bit of the shifted dividend (mag_a << Q).
    function automatic int fxp_iter(input int n, input int q);
        return n - 1 + q;
    endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One combinational radix-2 restoring division step.
module fxp_div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem,
    input  logic         dbit,
    input  logic [N-2:0] mag_b,
    output logic [N-1:0] rem_next,
    output logic         qbit
);

    logic [N:0]   trial;
    logic [N-1:0] diff;

    always_comb begin
        trial    = {rem, dbit};
        diff     = trial[N-1:0] - {1'b0, mag_b};
        qbit     = (trial >= {2'b00, mag_b});
        rem_next = qbit ? diff : trial[N-1:0];
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Multi-cycle sign-magnitude fixed-point divider (a/b) with valid/ready on both sides,
// divide-by-zero and saturation flags, and optional round-to-nearest.
module fxp_div_seq
    import fxp_pkg::*;
#(
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int ROUND = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic         dbz,
    output logic         ovf,
    output div_state_t   dbg_state
);

    localparam int             ITER    = fxp_iter(N, Q);
    localparam int             CW      = $clog2(ITER + 1);
    localparam logic [63:0]    MAX64   = fxp_max_mag(N);
    localparam logic [N-2:0]   MAX_MAG = MAX64[N-2:0];

    // Handshake: a transfer happens on any rising edge where valid && ready.
    // in_ready and out_valid are pure decodes of the state register.
    div_state_t      state, state_next;
    logic [CW-1:0]   cnt;
    logic            sign_q;
    logic [N-2:0]    mag_b_r;
    logic [N-1:0]    rem;
    logic [ITER-1:0] dvd;
    logic [ITER-2:0] quo;

    logic            accept, b_zero, last;
    logic [N-1:0]    rem_next;
    logic            qbit;
    logic [ITER-1:0] quo_full;
    logic            round_up;
    logic [ITER:0]   mag_fin;
    logic            sat;
    logic [N-2:0]    mag_res;
    logic [N-1:0]    q_fin;

    fxp_div_step #(.N(N)) u_step (
        .rem      (rem),
        .dbit     (dvd[ITER-1]),
        .mag_b    (mag_b_r),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        accept     = in_valid && (state == IDLE);
        b_zero     = (b[N-2:0] == '0);
        last       = (cnt == CW'(ITER - 1));
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = b_zero ? DONE : RUN;
            RUN:  if (last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Final result from the last step, evaluated combinationally so it lands on DONE entry.
    always_comb begin
        quo_full = {quo, qbit};
        round_up = (ROUND != 0) && ({rem_next, 1'b0} >= {2'b00, mag_b_r});
        mag_fin  = {1'b0, quo_full} + {{ITER{1'b0}}, round_up};
        sat      = (mag_fin > {{(ITER + 2 - N){1'b0}}, MAX_MAG});
        mag_res  = sat ? MAX_MAG : mag_fin[N-2:0];
        q_fin    = {sign_q && (mag_res != '0), mag_res};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sign_q  <= 1'b0;
            mag_b_r <= '0;
            rem     <= '0;
            dvd     <= '0;
            quo     <= '0;
            q       <= '0;
            dbz     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q  <= a[N-1] ^ b[N-1];
                        mag_b_r <= b[N-2:0];
                        rem     <= '0;
                        dvd     <= {a[N-2:0], {Q{1'b0}}};
                        quo     <= '0;
                        cnt     <= '0;
                        if (b_zero) begin
                            q   <= {a[N-1] ^ b[N-1], MAX_MAG};
                            dbz <= 1'b1;
                            ovf <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= {dvd[ITER-2:0], 1'b0};
                    quo <= quo_full[ITER-2:0];
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        q   <= q_fin;
                        dbz <= 1'b0;
                        ovf <= sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed bench for fxp_div_seq: two instances (truncate and round) share the operand bus.
module tb_fxp_div_seq;
    import fxp_pkg::*;

    localparam int N = 32;
    localparam int Q = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_ready;

    logic         in_ready, out_valid, dbz, ovf;
    logic [N-1:0] q;
    div_state_t   dbg_state;
    logic         in_ready_r, out_valid_r, dbz_r, ovf_r;
    logic [N-1:0] q_r;
    div_state_t   dbg_state_r;

    int n_checks = 0;
    int n_errors = 0;
    logic [N-1:0] exp_q[$];

    fxp_div_seq #(.N(N), .Q(Q), .ROUND(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .dbz(dbz), .ovf(ovf), .dbg_state(dbg_state)
    );

    fxp_div_seq #(.N(N), .Q(Q), .ROUND(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .a(a), .b(b), .out_valid(out_valid_r), .out_ready(out_ready),
        .q(q_r), .dbz(dbz_r), .ovf(ovf_r), .dbg_state(dbg_state_r)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one division, optionally hold the result under backpressure, then retire it.
    task automatic run_div(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                           input logic [N-1:0] eq0, input logic [N-1:0] eq1,
                           input logic edbz, input logic eovf, input int elat, input int hold);
        int lat;
        logic [N-1:0] e0;
        @(negedge clk);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
        exp_q.push_back(eq0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 200);
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        e0 = exp_q.pop_front();
        check({tag, "_q"}, 64'(q), 64'(e0));
        check({tag, "_dbz"}, {63'd0, dbz}, {63'd0, edbz});
        check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eovf});
        check({tag, "_q_round"}, 64'(q_r), 64'(eq1));
        check({tag, "_valid_round"}, {63'd0, out_valid_r}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 32'h0001_0000; b = 32'h0001_0000;
            check({tag, "_hold_q"}, 64'(q), 64'(e0));
            check({tag, "_hold_flags"}, {62'd0, dbz, ovf}, {62'd0, edbz, eovf});
            check({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
            check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_done_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_done_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_q_after"}, 64'(q), 64'(e0));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_q", 64'(q), 64'd0);
        check("rst_flags", {62'd0, dbz, ovf}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        run_div("div_6_2",   32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0003_0000, 1'b0, 1'b0, 47, 0);
        run_div("div_2_3",   32'h0002_0000, 32'h0003_0000, 32'h0000_AAAA, 32'h0000_AAAB, 1'b0, 1'b0, 47, 0);
        run_div("div_m2_3",  32'h8002_0000, 32'h0003_0000, 32'h8000_AAAA, 32'h8000_AAAB, 1'b0, 1'b0, 47, 0);
        run_div("div_6_m2",  32'h0006_0000, 32'h8002_0000, 32'h8003_0000, 32'h8003_0000, 1'b0, 1'b0, 47, 0);
        run_div("dbz",       32'h8005_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, 0);
        run_div("ovf",       32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 47, 0);
        run_div("zero_res",  32'h8000_0001, 32'h7FFF_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 47, 0);
        run_div("backpress", 32'h0002_0000, 32'h0003_0000, 32'h0000_AAAA, 32'h0000_AAAB, 1'b0, 1'b0, 47, 10);

        // Reset mid-RUN aborts the operation.
        @(negedge clk);
        a = 32'h0006_0000; b = 32'h0002_0000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrun_busy", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_valid", {63'd0, out_valid}, 64'd0);
        check("midrun_rst_q", 64'(q), 64'd0);
        check("midrun_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("div_1_4", 32'h0001_0000, 32'h0004_0000, 32'h0000_4000, 32'h0000_4000, 1'b0, 1'b0, 47, 0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
